data_sram_resp: RTL and testbench

- Memory-side responder for the CPU SRAM-like port: the slave end of the en/wen/addr/wdata/rdata interface that the CPU top drives.
- Word-organised RAM with per-byte write enables and configurable read latency; a valid-tagged pipeline delivers read data.
- Used as the data (or instruction) memory in simulation and FPGA builds, and as the golden slave for CPU-level benches.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/data_sram_resp_if.sv | 22 ++
 rtl/sram_byte_lane.sv | 33 +++
 rtl/data_sram_resp.sv | 98 +++++++++
 tb/tb_data_sram_resp.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the data_sram_resp SRAM responder.
// Feature macro: SRAM_ERR_EN (out-of-window error reporting).
package sram_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 8;
  localparam int MAX_RD_LAT = 4;
  localparam int WORD_W     = WORD_BYTES * LANE_W;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [WORD_W-1:0] data;
  } rd_stage_t;

  // Flags move every cycle; data only moves with a real response so rdata holds between reads.
  function automatic rd_stage_t stage_advance(rd_stage_t prev, rd_stage_t cur);
    rd_stage_t nxt;
    nxt.valid = prev.valid;
    nxt.err   = prev.err;
    nxt.data  = prev.valid ? prev.data : cur.data;
    return nxt;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU SRAM-like port bundle between the CPU top (master) and the memory responder (slave).
// Handshake: en is a single-cycle request that is always accepted (no ready); rvalid/err are
// single-cycle responses with no backpressure, and rdata is meaningful only while rvalid=1.
interface data_sram_resp_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output en, wen, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  en, wen, addr, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/sram_byte_lane.sv
// One 8-bit RAM bank: write-enabled storage plus a registered (synchronous) read port.
// The read register can be loaded with zero instead of RAM data (used for rejected reads).
module sram_byte_lane
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Read register only changes on a read request, so it also serves as the held rdata.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rclr ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Word-organised SRAM responder with byte write enables and an RD_LAT-deep read pipeline.
// Define SRAM_ERR_EN to reject and flag accesses outside the BASE_ADDR window.
module data_sram_resp
  import sram_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_resp_if.slave   bus
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("data_sram_resp: RD_LAT=%0d outside 1..%0d", RD_LAT, MAX_RD_LAT);
  end

  if ((BASE_ADDR & ((32'd4 << ADDR_W) - 32'd1)) != 32'd0) begin : g_bad_base
    $error("data_sram_resp: BASE_ADDR %h not aligned to the window size", BASE_ADDR);
  end

  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              in_win;
  logic              rd_req;
  logic              wr_req;
  logic [WORD_W-1:0] raw_word;
  logic              s0_valid;
  logic              s0_err;
  rd_stage_t         head;
  rd_stage_t         out_stage;

  assign offset = bus.addr - BASE_ADDR;
  assign idx    = offset[ADDR_W+1:2];

`ifdef SRAM_ERR_EN
  // Addresses below BASE_ADDR wrap to a huge offset and land out of window too.
  assign in_win = (offset[31:ADDR_W+2] == '0);
  logic unused_offset_bits;
  assign unused_offset_bits = ^offset[1:0];
`else
  assign in_win = 1'b1;
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};
`endif

  assign rd_req = bus.en && (bus.wen == 4'b0000);
  assign wr_req = bus.en && (bus.wen != 4'b0000) && in_win;

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    sram_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .we     (wr_req && bus.wen[i]),
      .re     (rd_req),
      .rclr   (!in_win),
      .idx    (idx),
      .wdata  (bus.wdata[i*LANE_W +: LANE_W]),
      .rdata  (raw_word[i*LANE_W +: LANE_W])
    );
  end

  // First stage: flags registered here, data held in the lane read registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_valid <= 1'b0;
      s0_err   <= 1'b0;
    end else begin
      s0_valid <= rd_req;
      s0_err   <= bus.en && !in_win;
    end
  end

  assign head = '{valid: s0_valid, err: s0_err, data: raw_word};

  if (RD_LAT <= 1) begin : g_lat1
    assign out_stage = head;
  end else begin : g_latn
    rd_stage_t pipe_q [RD_LAT-1];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int k = 0; k < RD_LAT - 1; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= stage_advance(head, pipe_q[0]);
        for (int k = 1; k < RD_LAT - 1; k++) pipe_q[k] <= stage_advance(pipe_q[k-1], pipe_q[k]);
      end
    end

    assign out_stage = pipe_q[RD_LAT-2];
  end

  assign bus.rdata  = out_stage.data;
  assign bus.rvalid = out_stage.valid;
  assign bus.err    = out_stage.err;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: three instances (RD_LAT 1, 3, 4) share one stimulus stream.
module tb_data_sram_resp;

  localparam int N     = 20;
  localparam int NDUT  = 3;
  localparam int MAX_L = 4;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rv;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  int errors = 0;
  int checks = 0;

  logic        rv_o [NDUT];
  logic        er_o [NDUT];
  logic [31:0] rd_o [NDUT];
  logic [31:0] last_data [NDUT];
  logic        last_known [NDUT];

  vec_t tbl [N];
  vec_t idle_vec;
  logic err_en;

  always #5 clk = ~clk;

  data_sram_resp_if if1 ();
  data_sram_resp_if if3 ();
  data_sram_resp_if if4 ();

  assign if1.en = en;  assign if1.wen = wen;  assign if1.addr = addr;  assign if1.wdata = wdata;
  assign if3.en = en;  assign if3.wen = wen;  assign if3.addr = addr;  assign if3.wdata = wdata;
  assign if4.en = en;  assign if4.wen = wen;  assign if4.addr = addr;  assign if4.wdata = wdata;

  assign rv_o[0] = if1.rvalid;  assign er_o[0] = if1.err;  assign rd_o[0] = if1.rdata;
  assign rv_o[1] = if3.rvalid;  assign er_o[1] = if3.err;  assign rd_o[1] = if3.rdata;
  assign rv_o[2] = if4.rvalid;  assign er_o[2] = if4.err;  assign rd_o[2] = if4.rdata;

  data_sram_resp #(.ADDR_W(10), .RD_LAT(1), .BASE_ADDR(32'h0)) u_dut_l1 (
    .clk(clk), .resetn(resetn), .bus(if1.slave));
  data_sram_resp #(.ADDR_W(10), .RD_LAT(3), .BASE_ADDR(32'h0)) u_dut_l3 (
    .clk(clk), .resetn(resetn), .bus(if3.slave));
  data_sram_resp #(.ADDR_W(10), .RD_LAT(4), .BASE_ADDR(32'h0)) u_dut_l4 (
    .clk(clk), .resetn(resetn), .bus(if4.slave));

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic vec_t mk(logic e, logic [3:0] w, logic [31:0] a, logic [31:0] wd,
                              logic rv, logic er, logic cd, logic [31:0] dat);
    vec_t v;
    v.en = e; v.wen = w; v.addr = a; v.wdata = wd;
    v.exp_rv = rv; v.exp_err = er; v.chk_data = cd; v.exp_data = dat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    en    = v.en;
    wen   = v.wen;
    addr  = v.addr;
    wdata = v.wdata;
  endtask

  task automatic check_idle_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s lat%0d rvalid", tag, lat_of(d)), {31'd0, rv_o[d]}, 32'd0);
      check($sformatf("%s lat%0d err", tag, lat_of(d)), {31'd0, er_o[d]}, 32'd0);
    end
  endtask

  initial begin
    int j;
    vec_t e;

`ifdef SRAM_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    idle_vec = mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    tbl[0]  = mk(1, 4'h0, 32'h0000, 32'h0,          1, 0, 0, 32'h0);
    tbl[1]  = mk(1, 4'hF, 32'h0010, 32'h1122_3344,  0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 4'h5, 32'h0010, 32'hAABB_CCDD,  0, 0, 0, 32'h0);
    tbl[3]  = mk(1, 4'h0, 32'h0010, 32'h0,          1, 0, 1, 32'h11BB_33DD);
    tbl[4]  = mk(1, 4'hF, 32'h0000, 32'h1,          0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 4'hF, 32'h0004, 32'h2,          0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 4'hF, 32'h0008, 32'h3,          0, 0, 0, 32'h0);
    tbl[7]  = mk(1, 4'h0, 32'h0000, 32'h0,          1, 0, 1, 32'h1);
    tbl[8]  = mk(1, 4'h0, 32'h0004, 32'h0,          1, 0, 1, 32'h2);
    tbl[9]  = mk(1, 4'h0, 32'h0008, 32'h0,          1, 0, 1, 32'h3);
    tbl[10] = mk(1, 4'hF, 32'h0020, 32'hDEAD_BEEF,  0, 0, 0, 32'h0);
    tbl[11] = mk(1, 4'h0, 32'h0020, 32'h0,          1, 0, 1, 32'hDEAD_BEEF);
    tbl[12] = idle_vec;
    tbl[13] = mk(1, 4'hF, 32'h1004, 32'h5555_5555,  0, err_en, 0, 32'h0);
    tbl[14] = mk(1, 4'h0, 32'h0004, 32'h0,          1, 0, 1, err_en ? 32'h2 : 32'h5555_5555);
    tbl[15] = mk(1, 4'h0, 32'h1000, 32'h0,          1, err_en, 1, err_en ? 32'h0 : 32'h1);
    tbl[16] = mk(1, 4'hF, 32'h0FFC, 32'hA5A5_5A5A,  0, 0, 0, 32'h0);
    tbl[17] = mk(1, 4'h0, 32'h0FFC, 32'h0,          1, 0, 1, 32'hA5A5_5A5A);
    tbl[18] = mk(1, 4'hA, 32'h0010, 32'hCC00_EE00,  0, 0, 0, 32'h0);
    tbl[19] = mk(1, 4'h0, 32'h0010, 32'h0,          1, 0, 1, 32'hCCBB_EEDD);

    // Reset values while resetn is held low.
    drive(idle_vec);
    repeat (3) @(negedge clk);
    check_idle_all("reset");
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset lat%0d rdata", lat_of(d)), rd_o[d], 32'h0);
      last_data[d]  = 32'h0;
      last_known[d] = 1'b1;
    end
    resetn = 1'b1;

    // Table: response to entry j is due RD_LAT negedges after it was driven.
    for (int k = 0; k < N + MAX_L + 1; k++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        j = k - lat_of(d);
        e = (j >= 0 && j < N) ? tbl[j] : idle_vec;
        check($sformatf("vec%0d lat%0d rvalid", j, lat_of(d)), {31'd0, rv_o[d]}, {31'd0, e.exp_rv});
        check($sformatf("vec%0d lat%0d err", j, lat_of(d)), {31'd0, er_o[d]}, {31'd0, e.exp_err});
        if (e.exp_rv && e.chk_data) begin
          check($sformatf("vec%0d lat%0d rdata", j, lat_of(d)), rd_o[d], e.exp_data);
          last_data[d]  = e.exp_data;
          last_known[d] = 1'b1;
        end else if (e.exp_rv) begin
          last_known[d] = 1'b0;
        end else if (last_known[d]) begin
          check($sformatf("vec%0d lat%0d rdata hold", j, lat_of(d)), rd_o[d], last_data[d]);
        end
      end
      if (k < N) drive(tbl[k]);
      else drive(idle_vec);
    end

    // Reset while reads are in flight: those responses must never appear.
    @(negedge clk);
    drive(mk(1, 4'h0, 32'h0000, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    drive(mk(1, 4'h0, 32'h0004, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    drive(idle_vec);
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle_all("midrst held");
      for (int d = 0; d < NDUT; d++)
        check($sformatf("midrst held lat%0d rdata", lat_of(d)), rd_o[d], 32'h0);
    end
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_idle_all($sformatf("midrst after c%0d", c));
    end

    // Memory contents survive reset.
    drive(mk(1, 4'h0, 32'h0020, 32'h0, 0, 0, 0, 32'h0));
    for (int c = 1; c <= MAX_L + 1; c++) begin
      @(negedge clk);
      drive(idle_vec);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("retain c%0d lat%0d rvalid", c, lat_of(d)), {31'd0, rv_o[d]},
              {31'd0, (c == lat_of(d))});
        if (c == lat_of(d))
          check($sformatf("retain lat%0d rdata", lat_of(d)), rd_o[d], 32'hDEAD_BEEF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
